// File: rtl/vec_switch_pkg.sv
// Shared types and helpers for the buffered core-to-core vector switch.
package vec_switch_pkg;

    localparam int LANES     = 16;
    localparam int MAX_CORES = 256;

    typedef logic [31:0]                  word_t;
    typedef word_t [LANES-1:0]            lanes_t;
    typedef logic [$clog2(MAX_CORES)-1:0] core_idx_t;

    // Round-robin pointer advance with wrap at the core count.
    function automatic int unsigned next_rr(input int unsigned ptr, input int unsigned core_size);
        int unsigned nxt;
        nxt = ptr + 1;
        if (nxt >= core_size) begin
            nxt = 0;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/switch_pair_fifo.sv
// Show-ahead FIFO for one (source, destination) core pair.
// Pointers carry one extra wrap bit so full/empty need no occupancy counter.
module switch_pair_fifo
    import vec_switch_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 16
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        push,
    input  logic                        pop,
    input  logic [WIDTH-1:0][31:0]      push_data,
    output logic                        full,
    output logic                        empty,
    output logic [WIDTH-1:0][31:0]      head
);

    localparam int PW = $clog2(DEPTH);

    logic [PW:0]       wr_ptr_q, wr_ptr_d;
    logic [PW:0]       rd_ptr_q, rd_ptr_d;
    word_t [WIDTH-1:0] mem_q [DEPTH];

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[PW] != rd_ptr_q[PW]) && (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
    assign head  = mem_q[rd_ptr_q[PW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push && !full) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop && !empty) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage is not reset: stale entries are unreachable once the pointers clear.
    always_ff @(posedge clock) begin
        if (push && !full) begin
            mem_q[wr_ptr_q[PW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/vec_switch_buffered.sv
// Buffered N-core vector switch: one FIFO per (source, destination) pair plus
// directed or round-robin any-source receive. Optional bypass: VEC_SWITCH_BYPASS_EN.
module vec_switch_buffered
    import vec_switch_pkg::*;
#(
    parameter int CORE_SIZE      = 4,
    parameter int WIDTH          = 16,
    parameter int DEPTH          = 4,
    parameter int CORE_ADDR_SIZE = $clog2(CORE_SIZE)
) (
    input  logic                                        clock,
    input  logic                                        reset,
    input  logic [CORE_SIZE-1:0]                        send_ready,
    input  logic [CORE_SIZE-1:0][CORE_ADDR_SIZE-1:0]    send_core_idx,
    input  logic [CORE_SIZE-1:0][WIDTH-1:0][31:0]       send_data,
    output logic [CORE_SIZE-1:0]                        send_ok,
    input  logic [CORE_SIZE-1:0]                        recv_request,
    input  logic [CORE_SIZE-1:0]                        recv_any,
    input  logic [CORE_SIZE-1:0][CORE_ADDR_SIZE-1:0]    recv_core_idx,
    output logic [CORE_SIZE-1:0]                        recv_ready,
    output logic [CORE_SIZE-1:0][CORE_ADDR_SIZE-1:0]    recv_src,
    output logic [CORE_SIZE-1:0][WIDTH-1:0][31:0]       recv_data
);

    logic [CORE_SIZE-1:0][CORE_SIZE-1:0]                   push_w, pop_w, full_w, empty_w;
    logic [CORE_SIZE-1:0][CORE_SIZE-1:0][WIDTH-1:0][31:0]  head_w;
    logic [CORE_SIZE-1:0][CORE_ADDR_SIZE-1:0]              rr_q, rr_d;
    logic [CORE_SIZE-1:0]                                  byp_sender;
    logic                                                  found, byp;
    int unsigned                                           src, gsrc;

    for (genvar s = 0; s < CORE_SIZE; s++) begin : g_src
        for (genvar d = 0; d < CORE_SIZE; d++) begin : g_dst
            switch_pair_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) u_fifo (
                .clock     (clock),
                .reset     (reset),
                .push      (push_w[s][d]),
                .pop       (pop_w[s][d]),
                .push_data (send_data[s]),
                .full      (full_w[s][d]),
                .empty     (empty_w[s][d]),
                .head      (head_w[s][d])
            );
        end
    end

    always_comb begin
        send_ok    = '0;
        recv_ready = '0;
        recv_src   = '0;
        recv_data  = '0;
        push_w     = '0;
        pop_w      = '0;
        byp_sender = '0;
        rr_d       = rr_q;
        found      = 1'b0;
        byp        = 1'b0;
        src        = 0;
        gsrc       = 0;

        for (int s = 0; s < CORE_SIZE; s++) begin
            if (reset && send_ready[s] && (int'(send_core_idx[s]) < CORE_SIZE)) begin
                send_ok[s] = !full_w[s][send_core_idx[s]];
            end
        end

        // A candidate source is granted if its queue holds data, or (bypass) it is sending here now.
        for (int d = 0; d < CORE_SIZE; d++) begin
            found = 1'b0;
            byp   = 1'b0;
            gsrc  = 0;
            if (reset && recv_request[d]) begin
                for (int k = 0; k < CORE_SIZE; k++) begin
                    if (!found && (recv_any[d] || k == 0)) begin
                        src = recv_any[d] ? (int'(rr_q[d]) + k) % CORE_SIZE : int'(recv_core_idx[d]);
                        if (src < CORE_SIZE) begin
                            if (!empty_w[src][d]) begin
                                found = 1'b1;
                                gsrc  = src;
                            end
`ifdef VEC_SWITCH_BYPASS_EN
                            else if (send_ok[src] && (int'(send_core_idx[src]) == d)) begin
                                found = 1'b1;
                                byp   = 1'b1;
                                gsrc  = src;
                            end
`endif
                        end
                    end
                end
                if (found) begin
                    recv_ready[d] = 1'b1;
                    recv_src[d]   = CORE_ADDR_SIZE'(gsrc);
                    if (byp) begin
                        recv_data[d]     = send_data[gsrc];
                        byp_sender[gsrc] = 1'b1;
                    end else begin
                        recv_data[d]   = head_w[gsrc][d];
                        pop_w[gsrc][d] = 1'b1;
                    end
                    if (recv_any[d]) begin
                        rr_d[d] = CORE_ADDR_SIZE'(next_rr(gsrc, CORE_SIZE));
                    end
                end
            end
        end

        for (int s = 0; s < CORE_SIZE; s++) begin
            if (send_ok[s] && !byp_sender[s]) begin
                push_w[s][send_core_idx[s]] = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rr_q <= '0;
        end else begin
            rr_q <= rr_d;
        end
    end

endmodule
